logistic_key_xor: RTL and testbench
===================================

# logistic_key_xor

Consumer end of the logistic-map sequence generator: accepts IEEE-754 single-precision chaotic values x in [0,1), converts each to a Q0.24 fraction, derives one key byte per value, and buffers the key bytes in a small FIFO. Plaintext bytes are XORed with buffered key bytes one-for-one on a valid/ready stream, producing ciphertext. Because XOR is its own inverse, the same block also decrypts. It sits between the logistic generator and the byte datapath of the chaotic cipher.

## Interface
- `DEPTH`, 4: key FIFO entries; power of two, 2..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `val_valid`  in  1  logistic value present.
- `val_data`  in  32  IEEE-754 single-precision logistic value.
- `val_ready`  out  1  key FIFO can take a value.
- `din_valid`  in  1  input byte present.
- `din`  in  8  plaintext or ciphertext byte.
- `din_ready`  out  1  input byte accepted this cycle.
- `dout_valid`  out  1  output byte present.
- `dout`  out  8  `din ^ key`.
- `dout_ready`  in  1  downstream accepts `dout`.
- `key_count`  out  5  number of key bytes currently in the FIFO.
- `byte_count`  out  16  number of bytes emitted; wraps 0xFFFF→0.
- `fmt_err`  out  1  sticky: a value outside [0,1) format was received.

## Operation
- **Value accept:** a value is accepted on a cycle with `val_valid & val_ready`.
- **Conversion (combinational at accept):**
  - s = `val_data[31]`, e = `val_data[30:23]`, m = {1,`val_data[22:0]`} (24 bits).
  - s=1 → frac=0.
  - e≥127 → frac=0xFFFFFF (saturate).
  - e≤102 → frac=0.
  - Otherwise frac = m >> (126−e).
- **Key byte:** key = frac[15:8]. It is pushed at the FIFO tail.
- **Format error:** `fmt_err` is set when an accepted value has s=1 or e=255. A key byte is still pushed. The flag clears only on reset.
- **Data accept:** `din_ready` = `key_count`≠0 & (!`dout_valid` | `dout_ready`).
- **On a data accept:**
  - pop the FIFO head;
  - `dout` ← `din` ^ head, registered;
  - `dout_valid` ← 1.
- **Output hold:** `dout` and `dout_valid` stay stable until `dout_ready`. On a handshake with no new accept, `dout_valid` ← 0.
- **Byte counter:** `byte_count` increments on each `dout_valid & dout_ready`.
- **FIFO:**
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `key_count` tracks occupancy 0..DEPTH.
  - Push only: +1. Pop only: −1. Simultaneous push and pop: unchanged, and both take effect.
  - `val_ready` = `rst_n` & (`key_count`≠DEPTH). There is no bypass when full, even if a pop occurs in the same cycle.
  - When empty, a value pushed this cycle is not usable for `din` until the next cycle (`din_ready`=0 while `key_count`=0).

## Timing
- **Reset values (asserted or in progress):**
  - `key_count`=0, `byte_count`=0, `fmt_err`=0.
  - `dout_valid`=0, `dout`=0x00.
  - `din_ready`=0, `val_ready`=0 while `rst_n`=0; `val_ready`=1 on the first cycle after release.
  - Pointers = 0.
- **Reset mid-operation:** FIFO contents, any pending output byte, and both counters are discarded.
- **Value to key availability:** 1 cycle. A value accepted at edge N enables `din_ready` from the cycle after edge N.
- **Byte latency:** a byte accepted at edge N appears on `dout` with `dout_valid` after edge N.
- **Throughput:** 1 byte/cycle and 1 value/cycle when `dout_ready`=1 and no FIFO stall.
- **Stable signals:** `key_count` and `byte_count` update on the same edge as their causing handshake.

## Test plan
1. **Nominal value:** reset; `val_data`=0x3F4A1CAC (0.7894) → frac=0xCA1CAC, key 0x1C, `key_count`=1; then `din`=0x55 → `dout`=0x49 one cycle after accept, `byte_count`=1.
2. **Boundary values:** push 0x3F800000 → key 0xFF, `fmt_err`=0; push 0x3F7FFFFF → key 0xFF; push 0x33800000 → frac=0x000001, key 0x00; push 0xBF4A1CAC → key 0x00, `fmt_err`=1 and it stays 1.
3. **Full FIFO:** push DEPTH values with no data → `key_count`=4, `val_ready`=0; a 5th value is held; then push and pop in the same cycle at count 3 → count stays 3.
4. **Backpressure:** `dout_ready`=0 with a byte pending → `dout` stable, `din_ready`=0, no FIFO pop; release → next byte accepted in the same cycle as the handshake.
5. **Empty FIFO:** `din_valid`=1 with empty FIFO → `din_ready`=0 until the cycle after the first key push.
6. **Reset and wrap:** reset asserted mid-stream with 2 keys and `dout_valid`=1 → all counts 0, `dout_valid`=0; run 65536 bytes → `byte_count` wraps to 0.

Source files
------------

// File: rtl/logistic_key_xor.sv
// logistic_key_xor: turns IEEE-754 logistic-map values in [0,1) into key
// bytes (Q0.24 fraction, bits [15:8]), buffers them in a small FIFO, and
// XORs them one-for-one onto a valid/ready byte stream. The same block
// encrypts and decrypts.
module logistic_key_xor #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        val_valid,
  input  logic [31:0] val_data,
  output logic        val_ready,
  input  logic        din_valid,
  input  logic [7:0]  din,
  output logic        din_ready,
  output logic        dout_valid,
  output logic [7:0]  dout,
  input  logic        dout_ready,
  output logic [4:0]  key_count,
  output logic [15:0] byte_count,
  output logic        fmt_err
);

  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  FULL = 5'(DEPTH);

  // Float -> Q0.24 with saturation at 1.0 and flush of tiny/negative values;
  // only bits [15:8] of the fraction become the key byte.
  function automatic logic [7:0] f32_to_key(input logic [31:0] v);
    logic [7:0]  e;
    logic [23:0] m;
    logic [7:0]  sh;
    logic [23:0] frac;
    e    = v[30:23];
    m    = {1'b1, v[22:0]};
    sh   = 8'd126 - e;
    frac = 24'h000000;
    if (v[31]) begin
      frac = 24'h000000;
    end else if (e >= 8'd127) begin
      frac = 24'hFFFFFF;
    end else if (e <= 8'd102) begin
      frac = 24'h000000;
    end else begin
      frac = m >> sh;
    end
    f32_to_key = frac[15:8];
  endfunction

  // Negative numbers and Inf/NaN encodings are not legal logistic values.
  function automatic logic f32_bad(input logic [31:0] v);
    f32_bad = v[31] | (v[30:23] == 8'hFF);
  endfunction

  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    cnt;
  logic [7:0]    key_p0;
  logic          bad_p0;
  logic [7:0]    dout_p1;
  logic          vld_p1;
  logic [15:0]   bcnt;
  logic          err;
  logic          push;
  logic          pop;
  logic          out_hs;

  // ---- p0: value conversion and handshake decode (combinational)
  assign key_p0    = f32_to_key(val_data);
  assign bad_p0    = f32_bad(val_data);
  assign val_ready = rst_n & (cnt != FULL);
  assign din_ready = (cnt != 5'd0) & (~vld_p1 | dout_ready);
  assign push      = val_valid & val_ready;
  assign pop       = din_valid & din_ready;
  assign out_hs    = vld_p1 & dout_ready;

  // Key storage: payload only, so no reset on the array.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= key_p0;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave count as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---- p1: registered ciphertext byte, held until downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p1 <= 8'h00;
      vld_p1  <= 1'b0;
    end else if (pop) begin
      dout_p1 <= din ^ fifo_mem[rd_ptr];
      vld_p1  <= 1'b1;
    end else if (out_hs) begin
      vld_p1  <= 1'b0;
    end
  end

  // Emitted-byte counter (wraps) and sticky format-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= 16'h0000;
      err  <= 1'b0;
    end else begin
      if (out_hs) begin
        bcnt <= bcnt + 16'h0001;
      end
      if (push && bad_p0) begin
        err <= 1'b1;
      end
    end
  end

  assign dout       = dout_p1;
  assign dout_valid = vld_p1;
  assign key_count  = cnt;
  assign byte_count = bcnt;
  assign fmt_err    = err;

endmodule

// File: tb/tb_logistic_key_xor.sv
// Testbench for logistic_key_xor: transaction-level model (key queue,
// real-valued conversion) checked every cycle, plus directed literal checks.
module tb_logistic_key_xor;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        val_valid;
  logic [31:0] val_data;
  logic        val_ready;
  logic        din_valid;
  logic [7:0]  din;
  logic        din_ready;
  logic        dout_valid;
  logic [7:0]  dout;
  logic        dout_ready;
  logic [4:0]  key_count;
  logic [15:0] byte_count;
  logic        fmt_err;

  int tests = 0;
  int fails = 0;

  logic [7:0]  keyq[$];
  logic        m_vld  = 1'b0;
  logic [7:0]  m_dout = 8'h00;
  logic [15:0] m_cnt  = 16'h0000;
  logic        m_err  = 1'b0;

  logistic_key_xor #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .val_valid(val_valid), .val_data(val_data), .val_ready(val_ready),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
    .key_count(key_count), .byte_count(byte_count), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Key byte from the real value: floor(x * 2^24) bits [15:8], saturating at 1.0.
  function automatic logic [7:0] model_key(input logic [31:0] v);
    int   ex;
    real  x;
    int   f;
    if (v[31]) return 8'h00;
    if (v[30:23] == 8'hFF) return 8'hFF;
    if (v[30:23] == 8'h00) return 8'h00;
    ex = int'(v[30:23]) - 127;
    x  = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** ex);
    if (x >= 1.0) f = 32'h00FFFFFF;
    else          f = $rtoi(x * 16777216.0);
    return f[15:8];
  endfunction

  function automatic logic model_bad(input logic [31:0] v);
    return v[31] || (v[30:23] == 8'hFF);
  endfunction

  function automatic logic exp_val_ready();
    return rst_n && (keyq.size() != DEPTH);
  endfunction

  function automatic logic exp_din_ready();
    return (keyq.size() != 0) && (!m_vld || dout_ready);
  endfunction

  task automatic model_reset();
    keyq.delete();
    m_vld  = 1'b0;
    m_dout = 8'h00;
    m_cnt  = 16'h0000;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    logic push, pop, hs;
    logic [7:0] head;
    push = val_valid && exp_val_ready();
    pop  = din_valid && exp_din_ready();
    hs   = m_vld && dout_ready;
    if (hs) m_cnt = m_cnt + 16'd1;
    if (pop) begin
      head   = keyq.pop_front();
      m_dout = din ^ head;
      m_vld  = 1'b1;
    end else if (hs) begin
      m_vld = 1'b0;
    end
    if (push) begin
      keyq.push_back(model_key(val_data));
      if (model_bad(val_data)) m_err = 1'b1;
    end
  endtask

  // Model advances on every active edge, or clears on reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Every cycle, at the falling edge, compare all outputs with the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("key_count",  32'(key_count),  32'(keyq.size()));
      chk("val_ready",  32'(val_ready),  32'(exp_val_ready()));
      chk("din_ready",  32'(din_ready),  32'(exp_din_ready()));
      chk("dout_valid", 32'(dout_valid), 32'(m_vld));
      chk("dout",       32'(dout),       32'(m_dout));
      chk("byte_count", 32'(byte_count), 32'(m_cnt));
      chk("fmt_err",    32'(fmt_err),    32'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; val_valid = 1'b0; val_data = 32'h0; din_valid = 1'b0;
    din = 8'h00; dout_ready = 1'b1;

    // Pin the model's conversion against hand-computed keys.
    chk("pin_nominal", 32'(model_key(32'h3F4A1CAC)), 32'h1C);
    chk("pin_one",     32'(model_key(32'h3F800000)), 32'hFF);
    chk("pin_max",     32'(model_key(32'h3F7FFFFF)), 32'hFF);
    chk("pin_tiny",    32'(model_key(32'h33800000)), 32'h00);
    chk("pin_quarter", 32'(model_key(32'h3EABCDEF)), 32'hE6);
    chk("pin_neg",     32'(model_key(32'hBF4A1CAC)), 32'h00);

    cyc(3);
    chk("rst_key_count", 32'(key_count), 0);
    chk("rst_val_ready", 32'(val_ready), 0);
    chk("rst_din_ready", 32'(din_ready), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_val_ready", 32'(val_ready), 1);
    cyc(1);

    // Nominal value then one byte.
    val_valid = 1'b1; val_data = 32'h3F4A1CAC; din_valid = 1'b1; din = 8'h55;
    cyc(1);
    chk("t1_key_count", 32'(key_count), 1);
    chk("t1_din_ready", 32'(din_ready), 1);
    val_valid = 1'b0;
    cyc(1);
    chk("t1_dout", 32'(dout), 32'h49);
    chk("t1_dout_valid", 32'(dout_valid), 1);
    din_valid = 1'b0;
    cyc(1);
    chk("t1_byte_count", 32'(byte_count), 1);

    // Boundary values.
    val_valid = 1'b1; val_data = 32'h3F800000;
    cyc(1);
    chk("t2_err_one", 32'(fmt_err), 0);
    val_data = 32'h3F7FFFFF;
    cyc(1);
    val_data = 32'h33800000;
    cyc(1);
    chk("t2_err_tiny", 32'(fmt_err), 0);
    val_data = 32'hBF4A1CAC;
    cyc(1);
    val_valid = 1'b0;
    chk("t2_err_neg", 32'(fmt_err), 1);
    chk("t2_full", 32'(key_count), 4);
    din_valid = 1'b1; din = 8'hA5;
    cyc(1); chk("t2_k1", 32'(dout), 32'h5A);
    cyc(1); chk("t2_k2", 32'(dout), 32'h5A);
    cyc(1); chk("t2_k3", 32'(dout), 32'hA5);
    cyc(1); chk("t2_k4", 32'(dout), 32'hA5);
    din_valid = 1'b0;
    cyc(1);
    chk("t2_err_sticky", 32'(fmt_err), 1);

    // Full FIFO, held fifth value, push+pop at count 3.
    val_valid = 1'b1;
    val_data = 32'h3F4A1CAC; cyc(1);
    val_data = 32'h3F7FFFFF; cyc(1);
    val_data = 32'h3F123456; cyc(1);
    val_data = 32'h3EABCDEF; cyc(1);
    val_data = 32'h3F7FFFFF;
    chk("t3_count4", 32'(key_count), 4);
    chk("t3_val_ready", 32'(val_ready), 0);
    cyc(2);
    chk("t3_held", 32'(key_count), 4);
    din_valid = 1'b1; din = 8'h00;
    cyc(1);
    chk("t3_pop_only", 32'(key_count), 3);
    chk("t3_dout_1c", 32'(dout), 32'h1C);
    cyc(1);
    chk("t3_push_pop", 32'(key_count), 3);
    chk("t3_dout_ff", 32'(dout), 32'hFF);

    // Backpressure.
    val_valid = 1'b0; dout_ready = 1'b0; din = 8'h11;
    #1;
    chk("t4_din_ready_lo", 32'(din_ready), 0);
    cyc(3);
    chk("t4_dout_stable", 32'(dout), 32'hFF);
    chk("t4_no_pop", 32'(key_count), 3);
    dout_ready = 1'b1;
    #1;
    chk("t4_din_ready_hi", 32'(din_ready), 1);
    cyc(1);
    chk("t4_dout_next", 32'(dout), 32'h25);
    chk("t4_count", 32'(key_count), 2);

    // Reset mid-stream with 2 keys and a pending byte.
    din_valid = 1'b0; dout_ready = 1'b0;
    cyc(1);
    chk("t6_pending", 32'(dout_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(key_count), 0);
    chk("t6_rst_valid", 32'(dout_valid), 0);
    chk("t6_rst_bytes", 32'(byte_count), 0);
    chk("t6_rst_err", 32'(fmt_err), 0);
    cyc(2);
    rst_n = 1'b1; dout_ready = 1'b1;
    cyc(1);

    // Empty FIFO: din waits until the cycle after the first key push.
    din_valid = 1'b1; din = 8'h77;
    cyc(2);
    chk("t5_empty_ready", 32'(din_ready), 0);
    chk("t5_empty_valid", 32'(dout_valid), 0);
    val_valid = 1'b1; val_data = 32'h3F4A1CAC;
    #1;
    chk("t5_same_cycle", 32'(din_ready), 0);
    cyc(1);
    val_valid = 1'b0;
    chk("t5_after_push", 32'(din_ready), 1);
    cyc(1);
    chk("t5_dout", 32'(dout), 32'h6B);
    din_valid = 1'b0;
    cyc(1);

    // Byte counter wrap at full throughput.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    val_valid = 1'b1; val_data = 32'h3F4A1CAC; din_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      din = 8'(i);
      cyc(1);
    end
    chk("t6_ffff", 32'(byte_count), 32'hFFFF);
    val_valid = 1'b0; din_valid = 1'b0;
    cyc(1);
    chk("t6_wrap", 32'(byte_count), 0);
    chk("t6_idle", 32'(dout_valid), 0);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
